data_mem_ctl: RTL

Parametrised successor to the single-port data RAM: a synchronous-write, registered-read data memory with configurable word width and depth. It adds a hardware clear sweep (after reset or on request), a read-valid strobe, write-first forwarding, out-of-range address detection, and saturating read/write access counters for cycle-accounting runs. It sits between the core's load/store stage and the testbench, replacing the flat 256×8 array.

---
 rtl/data_mem_ctl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctl.sv
// data_mem_ctl: parametrised data memory with a synchronous write port, a
// registered read port and a hardware clear sweep.
//
// Parameters
//   DW    data word width
//   AW    address width
//   DEPTH number of words (1..2**AW)
//   CNTW  access counter width
//
// Ports
//   CLK          sole clock, rising edge
//   reset        asynchronous active-low reset; restarts the clear sweep
//   Clear        request a full clear sweep (honoured only when idle)
//   DataAddress  word address for read/write
//   ReadMem      read request
//   WriteMem     write request
//   DataIn       write data
//   DataOut      registered read data, holds between reads
//   DataValid    one-cycle strobe: DataOut carries a new read result
//   Busy         clear sweep in progress, requests are ignored
//   AddrErr      one-cycle strobe: last accepted access was out of range
//   ReadCount    accepted reads, saturating
//   WriteCount   accepted writes, saturating
module data_mem_ctl #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int CNTW  = 16
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            Clear,
    input  logic [AW-1:0]   DataAddress,
    input  logic            ReadMem,
    input  logic            WriteMem,
    input  logic [DW-1:0]   DataIn,
    output logic [DW-1:0]   DataOut,
    output logic            DataValid,
    output logic            Busy,
    output logic            AddrErr,
    output logic [CNTW-1:0] ReadCount,
    output logic [CNTW-1:0] WriteCount
);

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
    // One extra bit so that DEPTH == 2**AW is representable.
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

    state_t        state, state_next;
    logic [AW-1:0] ptr, ptr_next;

    logic [DW-1:0] core [DEPTH];

    logic          in_range;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          rd_do;
    logic          wr_do;
    logic          clr_do;
    logic [DW-1:0] rd_data;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + CNTW'(1);
    endfunction

    // Request decode: sweep owns the write port; otherwise the idle
    // priority is Clear, then the read/write access.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        mem_we     = 1'b0;
        mem_addr   = ptr;
        mem_wdata  = '0;
        rd_do      = 1'b0;
        wr_do      = 1'b0;
        clr_do     = 1'b0;
        rd_data    = '0;
        in_range   = ({1'b0, DataAddress} < DEPTH_EXT);

        case (state)
            SWEEP: begin
                mem_we = 1'b1;
                if (ptr == LAST) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + AW'(1);
                end
            end
            IDLE: begin
                if (Clear) begin
                    clr_do     = 1'b1;
                    state_next = SWEEP;
                    ptr_next   = '0;
                end else begin
                    rd_do = ReadMem;
                    wr_do = WriteMem;
                    if (WriteMem && in_range) begin
                        mem_we    = 1'b1;
                        mem_addr  = DataAddress;
                        mem_wdata = DataIn;
                    end
                    // Write-first: a same-cycle write is forwarded to the read.
                    // Out-of-range reads return zero.
                    if (in_range) begin
                        rd_data = WriteMem ? DataIn : core[DataAddress];
                    end
                end
            end
            default: begin
                state_next = SWEEP;
                ptr_next   = '0;
            end
        endcase
    end

    // Stage boundary: array write port (the array is not reset; the sweep
    // that follows every reset clears it).
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            core[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= SWEEP;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Stage boundary: registered read response, strobes and counters.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            DataOut    <= '0;
            DataValid  <= 1'b0;
            AddrErr    <= 1'b0;
            ReadCount  <= '0;
            WriteCount <= '0;
        end else begin
            DataValid <= rd_do;
            AddrErr   <= (rd_do || wr_do) && !in_range;
            if (rd_do) begin
                DataOut <= rd_data;
            end
            if (clr_do) begin
                ReadCount  <= '0;
                WriteCount <= '0;
            end else begin
                if (rd_do) begin
                    ReadCount <= sat_inc(ReadCount);
                end
                if (wr_do) begin
                    WriteCount <= sat_inc(WriteCount);
                end
            end
        end
    end

    // Derived from the state register only; no path from the inputs.
    assign Busy = (state == SWEEP);

endmodule
